pe_column_feeder: RTL

//  Transmit side of the PE input interface: drives win/wwrite, then datain/active, into the top PE
//  of a ROWS-deep PE column. A host fills a weight buffer and a data FIFO; on start the block

---
 rtl/pe_column_feeder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pe_column_feeder.sv
// Transmit side of the PE input interface: buffers host weights and activations,
// then shifts the weights into a ROWS-deep PE column, streams activations and drains.
module pe_column_feeder #(
  parameter int ROWS   = 4,
  parameter int DDEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_valid,
  input  logic        i_wr_sel,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_ready,
  input  logic        i_start,
  input  logic [7:0]  i_num_vec,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_pe_win,
  output logic        o_pe_wwrite,
  output logic [7:0]  o_pe_datain,
  output logic        o_pe_active,
  output logic [15:0] o_pe_sumin
);
  localparam int WCW  = $clog2(ROWS + 1);
  localparam int WIDX = $clog2(ROWS);
  localparam int PW   = $clog2(DDEPTH);
  localparam int FCW  = $clog2(DDEPTH + 1);
  localparam logic [WCW-1:0] ROWS_C   = WCW'(ROWS);
  localparam logic [FCW-1:0] DDEPTH_C = FCW'(DDEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_wbuf [ROWS];
  logic [7:0]      r_fifo [DDEPTH];
  logic [WCW-1:0]  r_wcnt;
  logic [WCW-1:0]  r_phase;
  logic [WCW-1:0]  w_phase_nxt;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [FCW-1:0]  r_fcnt;
  logic [7:0]      r_vec_left;
  logic [7:0]      w_vec_nxt;
  logic            r_busy, r_done, r_wwrite, r_active;
  logic [7:0]      r_win, r_datain;
  logic            w_busy_nxt, w_done_nxt, w_wwrite_nxt, w_active_nxt;
  logic [7:0]      w_win_nxt, w_datain_nxt;
  logic            w_wr_ready, w_push_w, w_push_d, w_pop, w_start_ok, w_phase_last;
  logic [WIDX-1:0] w_widx, w_ridx;

  assign o_wr_ready  = w_wr_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pe_win    = r_win;
  assign o_pe_wwrite = r_wwrite;
  assign o_pe_datain = r_datain;
  assign o_pe_active = r_active;
  assign o_pe_sumin  = 16'h0000;

  // Handshake and FIFO control decoded from registered state
  always_comb begin
    w_wr_ready   = i_wr_sel ? (r_fcnt < DDEPTH_C) : ((r_state == S_IDLE) && (r_wcnt < ROWS_C));
    w_push_w     = i_wr_valid && !i_wr_sel && w_wr_ready;
    w_push_d     = i_wr_valid && i_wr_sel && w_wr_ready;
    w_start_ok   = i_start && (r_state == S_IDLE) && (r_wcnt == ROWS_C);
    w_pop        = (r_state == S_STREAM) && (r_fcnt != FCW'(0));
    w_phase_last = (r_phase == (ROWS_C - WCW'(1)));
    w_widx       = WIDX'(r_wcnt);
    // Last-written weight leaves first so PE k ends up holding weight k
    w_ridx       = WIDX'(ROWS_C - WCW'(1) - r_phase);
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = WCW'(0);
    w_vec_nxt    = r_vec_left;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_win_nxt    = r_win;
    w_wwrite_nxt = 1'b0;
    w_datain_nxt = 8'h00;
    w_active_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = w_start_ok;
        if (w_start_ok) begin
          w_state_nxt = S_WLOAD;
          w_vec_nxt   = i_num_vec;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WLOAD: begin
        w_wwrite_nxt = 1'b1;
        w_win_nxt    = r_wbuf[w_ridx];
        if (w_phase_last) begin
          w_state_nxt = (r_vec_left != 8'd0) ? S_STREAM : S_DRAIN;
        end else begin
          w_phase_nxt = r_phase + WCW'(1);
        end
      end
      S_STREAM: begin
        if (w_pop) begin
          w_active_nxt = 1'b1;
          w_datain_nxt = r_fifo[r_rptr];
          w_vec_nxt    = r_vec_left - 8'd1;
          if (r_vec_left == 8'd1) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_STREAM;
          end
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (w_phase_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_phase_nxt = r_phase + WCW'(1);
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_phase    <= WCW'(0);
      r_wcnt     <= WCW'(0);
      r_wptr     <= PW'(0);
      r_rptr     <= PW'(0);
      r_fcnt     <= FCW'(0);
      r_vec_left <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_win      <= 8'h00;
      r_wwrite   <= 1'b0;
      r_datain   <= 8'h00;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_vec_left <= w_vec_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_win      <= w_win_nxt;
      r_wwrite   <= w_wwrite_nxt;
      r_datain   <= w_datain_nxt;
      r_active   <= w_active_nxt;
      if (r_state == S_DONE) begin
        r_wcnt <= WCW'(0);
      end else if (w_push_w) begin
        r_wcnt <= r_wcnt + WCW'(1);
      end
      if (w_push_d) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push_d && !w_pop) begin
        r_fcnt <= r_fcnt + FCW'(1);
      end else if (w_pop && !w_push_d) begin
        r_fcnt <= r_fcnt - FCW'(1);
      end
    end
  end

  // Buffer storage; validity is tracked by the counters, so no reset is needed
  always_ff @(posedge i_clk) begin
    if (w_push_w) begin
      r_wbuf[w_widx] <= i_wr_data;
    end
    if (w_push_d) begin
      r_fifo[r_wptr] <= i_wr_data;
    end
  end
endmodule
